btn_cond: RTL and testbench

//   Conditions the three raw push-button inputs (left, right, fire) before they reach the player

---
 rtl/space_pkg.sv | 16 +
 rtl/btn_debounce.sv | 48 ++++
 rtl/btn_cond.sv | 86 ++++++++
 tb/tb_btn_cond.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/space_pkg.sv
// Shared constants for the button-conditioning path: channel indices and
// production debounce/cooldown defaults used by btn_cond.
package space_pkg;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_FIRE  = 2;
  localparam int NUM_BTN   = 3;

  // 10 ms debounce and 50 ms fire cooldown at 50 MHz
  localparam int DB_LIMIT_DEF = 500000;
  localparam int DB_W_DEF     = 19;
  localparam int FIRE_GAP_DEF = 2500000;
  localparam int GAP_W_DEF    = 22;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser followed by a counter that accepts
// a new level only after DB_LIMIT consecutive samples that differ from the current one.
module btn_debounce #(
  parameter int DB_LIMIT = 500000,
  parameter int DB_W     = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_LIMIT - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Any sample that matches the current level restarts the count from zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/btn_cond.sv
// Button conditioning: per-channel sync/debounce, left/right conflict masking and a
// rate-limited one-cycle fire strobe. Define FIRE_AUTO_REPEAT_EN for repeat-while-held fire.
module btn_cond
  import space_pkg::*;
#(
  parameter int DB_LIMIT = DB_LIMIT_DEF,
  parameter int DB_W     = DB_W_DEF,
  parameter int FIRE_GAP = FIRE_GAP_DEF,
  parameter int GAP_W    = GAP_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  output logic       move_left,
  output logic       move_right,
  output logic       fire_pulse,
  output logic [2:0] btn_state
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(FIRE_GAP);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] stable;
  logic               fire_prev_q;
  logic               fire_pulse_q, fire_pulse_d;
  logic [GAP_W-1:0]   cd_q, cd_d;
  logic               fire_rise;
  logic               fire_want;

  assign raw[BTN_LEFT]  = btn_left;
  assign raw[BTN_RIGHT] = btn_right;
  assign raw[BTN_FIRE]  = btn_fire;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(
      .DB_LIMIT (DB_LIMIT),
      .DB_W     (DB_W)
    ) u_db (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (raw[g]),
      .stable_o (stable[g])
    );
  end

  assign fire_rise = stable[BTN_FIRE] & ~fire_prev_q;

`ifdef FIRE_AUTO_REPEAT_EN
  // Holding fire re-arms whenever the cooldown has fully drained.
  assign fire_want = stable[BTN_FIRE];
`else
  assign fire_want = fire_rise;
`endif

  // A request arriving during cooldown is dropped, never queued.
  always_comb begin
    fire_pulse_d = fire_want && (cd_q == '0);
    if (fire_pulse_d) begin
      cd_d = GAP_LOAD;
    end else if (cd_q != '0) begin
      cd_d = cd_q - 1'b1;
    end else begin
      cd_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fire_prev_q  <= 1'b0;
      fire_pulse_q <= 1'b0;
      cd_q         <= '0;
    end else begin
      fire_prev_q  <= stable[BTN_FIRE];
      fire_pulse_q <= fire_pulse_d;
      cd_q         <= cd_d;
    end
  end

  assign move_left  = stable[BTN_LEFT] & ~stable[BTN_RIGHT];
  assign move_right = stable[BTN_RIGHT] & ~stable[BTN_LEFT];
  assign fire_pulse = fire_pulse_q;
  assign btn_state  = stable;

endmodule

// File: tb/tb_btn_cond.sv
// Randomised and directed bench for btn_cond, compared against a window-based
// reference model of debounce and a time-since-last-shot model of the fire cooldown.
module tb_btn_cond;
  import space_pkg::*;

  localparam int DBL = 4;
  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0;
  logic       move_left, move_right, fire_pulse;
  logic [2:0] btn_state;

  btn_cond #(
    .DB_LIMIT (DBL),
    .DB_W     (3),
    .FIRE_GAP (GAP),
    .GAP_W    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_fire   (btn_fire),
    .move_left  (move_left),
    .move_right (move_right),
    .fire_pulse (fire_pulse),
    .btn_state  (btn_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a level is accepted once the last DBL synchronised samples
  // (raw samples taken 2..DBL+1 edges ago) all disagree with the current level.
  bit      hist[NUM_BTN][$];
  bit      m_stable[NUM_BTN];
  bit      m_prev_fire;
  bit      m_pulse;
  longint  cyc;
  longint  last_pulse;

  task automatic model_reset();
    for (int ch = 0; ch < NUM_BTN; ch++) begin
      hist[ch].delete();
      for (int j = 0; j < DBL + 2; j++) hist[ch].push_back(1'b0);
      m_stable[ch] = 1'b0;
    end
    m_prev_fire = 1'b0;
    m_pulse     = 1'b0;
    cyc         = 0;
    last_pulse  = -1000;
  endtask

  task automatic model_edge(input bit [2:0] rw);
    bit want, ready, all_diff;
    int n;
`ifdef FIRE_AUTO_REPEAT_EN
    want = m_stable[BTN_FIRE];
`else
    want = m_stable[BTN_FIRE] && !m_prev_fire;
`endif
    ready   = (cyc - last_pulse) >= GAP + 1;
    m_pulse = want && ready;
    if (m_pulse) last_pulse = cyc;
    m_prev_fire = m_stable[BTN_FIRE];
    for (int ch = 0; ch < NUM_BTN; ch++) begin
      hist[ch].push_back(rw[ch]);
      if (hist[ch].size() > 16) void'(hist[ch].pop_front());
      n = hist[ch].size();
      all_diff = 1'b1;
      for (int j = 2; j <= DBL + 1; j++)
        if (hist[ch][n-1-j] == m_stable[ch]) all_diff = 1'b0;
      if (all_diff) m_stable[ch] = !m_stable[ch];
    end
    cyc++;
  endtask

  // Drive at the falling edge, let one rising edge happen, check at the next falling edge.
  task automatic step(input bit [2:0] rw);
    btn_left  = rw[BTN_LEFT];
    btn_right = rw[BTN_RIGHT];
    btn_fire  = rw[BTN_FIRE];
    @(posedge clk);
    model_edge(rw);
    @(negedge clk);
    check_eq("move_left", move_left, m_stable[BTN_LEFT] && !m_stable[BTN_RIGHT]);
    check_eq("move_right", move_right, m_stable[BTN_RIGHT] && !m_stable[BTN_LEFT]);
    check_eq("fire_pulse", fire_pulse, m_pulse);
    check_eq("btn_state", btn_state, {m_stable[BTN_FIRE], m_stable[BTN_RIGHT], m_stable[BTN_LEFT]});
    if (fire_pulse) pulses++;
  endtask

  task automatic steps(input bit [2:0] rw, input int n);
    for (int i = 0; i < n; i++) step(rw);
  endtask

  initial begin
    bit [2:0] r;
    bit       seen;
    int       p0;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1'b0;

    // Buttons held, then reset asserted mid-cycle clears outputs without a clock edge.
    steps(3'b111, 10);
    check_eq("pre_rst_state", btn_state, 3'b111);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_move_left", move_left, 0);
    check_eq("rst_move_right", move_right, 0);
    check_eq("rst_fire_pulse", fire_pulse, 0);
    check_eq("rst_btn_state", btn_state, 0);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    p0 = pulses;
    steps(3'b111, 12);
    check_eq("held_across_reset_pulse", pulses - p0, 1);
    steps(3'b000, 12);

    // Left press latency: accepted on the sixth edge after first sampling it.
    steps(3'b001, 5);
    check_eq("left_lat5", move_left, 0);
    step(3'b001);
    check_eq("left_lat6", move_left, 1);
    check_eq("left_state", btn_state, 3'b001);
    steps(3'b000, 10);

    // Three-cycle glitch never passes.
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin step(3'b001); seen |= move_left; end
    for (int i = 0; i < 10; i++) begin step(3'b000); seen |= move_left; end
    check_eq("glitch_left", seen, 0);

    // Conflict, then release right.
    steps(3'b011, 8);
    check_eq("both_state", btn_state, 3'b011);
    check_eq("both_ml", move_left, 0);
    check_eq("both_mr", move_right, 0);
    steps(3'b001, 5);
    check_eq("relR_lat5", move_left, 0);
    step(3'b001);
    check_eq("relR_lat6", move_left, 1);
    steps(3'b000, 12);

    // Re-press inside the cooldown is dropped; a later press fires again.
    p0 = pulses;
    steps(3'b100, 4);
    steps(3'b000, 4);
    steps(3'b100, 4);
    steps(3'b000, 12);
    check_eq("cd_drop_pulses", pulses - p0, 1);
    steps(3'b100, 4);
    steps(3'b000, 12);
    check_eq("cd_second_pulses", pulses - p0, 2);

    // Long hold.
    p0 = pulses;
    steps(3'b100, 40);
    steps(3'b000, 20);
`ifdef FIRE_AUTO_REPEAT_EN
    check_eq("hold40_pulses", pulses - p0, 5);
`else
    check_eq("hold40_pulses", pulses - p0, 1);
`endif

    // Random button activity with slowly varying levels.
    r = 3'b000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < NUM_BTN; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      step(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
